// File: rtl/mem_arbiter_if.sv
// Bundle of client request/response and memory-side signals around mem_arbiter.
// The arbiter takes the slave view; whoever drives the clients and memory takes the master view.
interface mem_arbiter_if #(
  parameter int unsigned w = 4,
  parameter int unsigned n = 4
);
  logic         valid0;
  logic         wr_rd0;
  logic [n-1:0] addr0;
  logic [w-1:0] wdata0;
  logic         ready0;
  logic [w-1:0] rdata0;
  logic         err0;

  logic         valid1;
  logic         wr_rd1;
  logic [n-1:0] addr1;
  logic [w-1:0] wdata1;
  logic         ready1;
  logic [w-1:0] rdata1;
  logic         err1;

  logic         m_valid;
  logic         m_wr_rd;
  logic [n-1:0] m_addr;
  logic [w-1:0] m_wdata;
  logic [w-1:0] m_rdata;
  logic         m_ready;

  modport slave (
    input  valid0, wr_rd0, addr0, wdata0,
    input  valid1, wr_rd1, addr1, wdata1,
    input  m_rdata, m_ready,
    output ready0, rdata0, err0,
    output ready1, rdata1, err1,
    output m_valid, m_wr_rd, m_addr, m_wdata
  );

  modport master (
    output valid0, wr_rd0, addr0, wdata0,
    output valid1, wr_rd1, addr1, wdata1,
    output m_rdata, m_ready,
    input  ready0, rdata0, err0,
    input  ready1, rdata1, err1,
    input  m_valid, m_wr_rd, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter serialising read/write requests onto a single-port memory,
// with a per-access timeout that reports an error to the granted client.
module mem_arbiter #(
  parameter int unsigned w  = 4,
  parameter int unsigned d  = 16,
  parameter int unsigned n  = $clog2(d),
  parameter int unsigned to = 15,
  parameter int unsigned tw = $clog2(to + 1)
) (
  input logic          clk,
  input logic          res,
  mem_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          gnt_q, gnt_d;
  logic [tw-1:0] cnt_q, cnt_d;
  logic          m_valid_q, m_valid_d;
  logic          m_wr_rd_q, m_wr_rd_d;
  logic [n-1:0]  m_addr_q, m_addr_d;
  logic [w-1:0]  m_wdata_q, m_wdata_d;
  logic [1:0]    ready_q, ready_d;
  logic [1:0]    err_q, err_d;
  logic [w-1:0]  rdata0_q, rdata0_d;
  logic [w-1:0]  rdata1_q, rdata1_d;

  logic sel;
  logic grant;
  logic timeout;

  // A memory ready still high from the previous access must not start a new one.
  assign grant   = (bus_io.valid0 | bus_io.valid1) & ~bus_io.m_ready;
  assign sel     = (bus_io.valid0 & bus_io.valid1) ? prio_q : bus_io.valid1;
  assign timeout = (cnt_q == tw'(to - 1));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StWait;
      StWait:  if (bus_io.m_ready || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prio_d    = prio_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_wr_rd_d = m_wr_rd_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ready_d   = '0;
    err_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          gnt_d     = sel;
          m_valid_d = 1'b1;
          m_wr_rd_d = sel ? bus_io.wr_rd1 : bus_io.wr_rd0;
          m_addr_d  = sel ? bus_io.addr1  : bus_io.addr0;
          m_wdata_d = sel ? bus_io.wdata1 : bus_io.wdata0;
          cnt_d     = '0;
        end
      end
      StWait: begin
        if (bus_io.m_ready) begin
          if (!m_wr_rd_q) begin
            if (gnt_q) rdata1_d = bus_io.m_rdata;
            else       rdata0_d = bus_io.m_rdata;
          end
          ready_d[gnt_q] = 1'b1;
          m_valid_d      = 1'b0;
        end else if (timeout) begin
          ready_d[gnt_q] = 1'b1;
          err_d[gnt_q]   = 1'b1;
          m_valid_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: prio_d = ~gnt_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      prio_q    <= 1'b0;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_wr_rd_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      ready_q   <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_wr_rd_q <= m_wr_rd_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus_io.m_valid = m_valid_q;
  assign bus_io.m_wr_rd = m_wr_rd_q;
  assign bus_io.m_addr  = m_addr_q;
  assign bus_io.m_wdata = m_wdata_q;
  assign bus_io.ready0  = ready_q[0];
  assign bus_io.ready1  = ready_q[1];
  assign bus_io.err0    = err_q[0];
  assign bus_io.err1    = err_q[1];
  assign bus_io.rdata0  = rdata0_q;
  assign bus_io.rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: rounds of client requests feed a transaction-level model,
// a memory responder serves the port, and a monitor checks every grant and ready pulse.
module tb_mem_arbiter;
  localparam int unsigned W  = 4;
  localparam int unsigned D  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  mem_arbiter_if #(.w(W), .n(N)) bus ();

  mem_arbiter #(.w(W), .d(D), .n(N), .to(TO), .tw(4)) dut (
    .clk    (clk),
    .res    (res),
    .bus_io (bus)
  );

  typedef struct {
    int           c;
    bit           wr;
    logic [N-1:0] addr;
    logic [W-1:0] wdata;
    bit           err;
    logic [W-1:0] rdata;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [W-1:0] ref_mem   [D];
  logic [W-1:0] ref_rdata [2];
  bit           ref_prio;

  // Memory environment
  logic [W-1:0] mem_arr [D];
  bit mem_mute    = 1'b0;
  bit stale_force = 1'b0;
  int mem_lat     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory responder: answers mem_lat cycles after seeing m_valid unless muted.
  initial begin
    int mem_wait;
    mem_wait    = 0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    for (int i = 0; i < D; i++) mem_arr[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stale_force) begin
        bus.m_ready = 1'b1;
      end else if (bus.m_ready) begin
        bus.m_ready = 1'b0;
      end else if (bus.m_valid && !mem_mute) begin
        if (mem_wait < mem_lat) begin
          mem_wait++;
        end else begin
          if (bus.m_wr_rd) begin
            mem_arr[bus.m_addr] = bus.m_wdata;
            bus.m_rdata = W'($urandom);
          end else begin
            bus.m_rdata = mem_arr[bus.m_addr];
          end
          bus.m_ready = 1'b1;
          mem_wait    = 0;
        end
      end else begin
        mem_wait = 0;
      end
    end
  end

  // Clients release valid once their ready pulse is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ready0 === 1'b1) bus.valid0 = 1'b0;
      if (bus.ready1 === 1'b1) bus.valid1 = 1'b0;
    end
  end

  // Monitor
  initial begin
    int   cyc;
    int   grant_cyc;
    bit   prev_mv;
    exp_t e;
    cyc       = 0;
    grant_cyc = 0;
    prev_mv   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (res === 1'b1) begin
        if (bus.m_valid && !prev_mv) begin
          if (exp_q.size() == 0) begin
            fail("grant with no pending request");
          end else begin
            chk("m_wr_rd", bus.m_wr_rd, exp_q[0].wr);
            chk("m_addr", bus.m_addr, exp_q[0].addr);
            if (exp_q[0].wr) chk("m_wdata", bus.m_wdata, exp_q[0].wdata);
            grant_cyc = cyc;
          end
        end
        if (bus.ready0 || bus.ready1) begin
          if (exp_q.size() == 0) begin
            fail("ready with no pending request");
          end else begin
            e = exp_q.pop_front();
            chk("ready client", {30'd0, bus.ready1, bus.ready0}, (e.c != 0) ? 2 : 1);
            chk("err", (e.c != 0) ? bus.err1 : bus.err0, e.err);
            chk("rdata", (e.c != 0) ? bus.rdata1 : bus.rdata0, e.rdata);
            chk("m_valid during ready", bus.m_valid, 0);
            if (e.err) chk("timeout latency", cyc - grant_cyc, TO);
          end
        end else if (bus.err0 || bus.err1) begin
          fail("err without ready");
        end
      end
      prev_mv = bus.m_valid;
    end
  end

  task automatic push_one(input int c, input bit wr, input logic [N-1:0] a,
                          input logic [W-1:0] dd, input bit mute);
    exp_t e;
    e.c     = c;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = dd;
    e.err   = mute;
    if (!mute) begin
      if (wr) ref_mem[a] = dd;
      else    ref_rdata[c] = ref_mem[a];
    end
    e.rdata  = ref_rdata[c];
    ref_prio = (c == 0);
    exp_q.push_back(e);
  endtask

  task automatic start_round(input bit v0, input bit w0, input logic [N-1:0] a0,
                             input logic [W-1:0] d0, input bit v1, input bit w1,
                             input logic [N-1:0] a1, input logic [W-1:0] d1, input bit mute);
    mem_mute = mute;
    if (v0 && v1) begin
      if (!ref_prio) begin
        push_one(0, w0, a0, d0, mute);
        push_one(1, w1, a1, d1, mute);
      end else begin
        push_one(1, w1, a1, d1, mute);
        push_one(0, w0, a0, d0, mute);
      end
    end else if (v0) begin
      push_one(0, w0, a0, d0, mute);
    end else if (v1) begin
      push_one(1, w1, a1, d1, mute);
    end
    if (v0) begin
      bus.wr_rd0 = w0;
      bus.addr0  = a0;
      bus.wdata0 = d0;
    end
    if (v1) begin
      bus.wr_rd1 = w1;
      bus.addr1  = a1;
      bus.wdata1 = d1;
    end
    bus.valid0 = v0;
    bus.valid1 = v1;
  endtask

  task automatic wait_round();
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.valid0 && !bus.valid1) break;
    end
    if (k == 300) begin
      fail("round did not complete");
      exp_q.delete();
      bus.valid0 = 1'b0;
      bus.valid1 = 1'b0;
    end
  endtask

  task automatic do_round(input bit v0, input bit w0, input logic [N-1:0] a0,
                          input logic [W-1:0] d0, input bit v1, input bit w1,
                          input logic [N-1:0] a1, input logic [W-1:0] d1, input bit mute);
    start_round(v0, w0, a0, d0, v1, w1, a1, d1, mute);
    wait_round();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " m_valid"}, bus.m_valid, 0);
    chk({tag, " ready0"}, bus.ready0, 0);
    chk({tag, " ready1"}, bus.ready1, 0);
    chk({tag, " err0"}, bus.err0, 0);
    chk({tag, " err1"}, bus.err1, 0);
    chk({tag, " rdata0"}, bus.rdata0, 0);
    chk({tag, " rdata1"}, bus.rdata1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    res        = 1'b0;
    bus.valid0 = 1'b0;
    bus.valid1 = 1'b0;
    bus.wr_rd0 = 1'b0;
    bus.wr_rd1 = 1'b0;
    bus.addr0  = '0;
    bus.addr1  = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    ref_prio     = 1'b0;

    #2;
    check_cleared("reset");
    chk("reset m_addr", bus.m_addr, 0);
    chk("reset m_wdata", bus.m_wdata, 0);
    chk("reset m_wr_rd", bus.m_wr_rd, 0);
    @(negedge clk);
    @(negedge clk);
    res = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous requests after reset, then continuous contention
    do_round(1, 1, 4'd1, 4'd5, 1, 0, 4'd1, 4'd0, 0);
    for (int i = 0; i < 3; i++) begin
      do_round(1, 1'($urandom), 4'($urandom), 4'($urandom),
               1, 1'($urandom), 4'($urandom), 4'($urandom), 0);
    end

    // Single write then read
    mem_lat = 1;
    do_round(1, 1, 4'd3, 4'hA, 0, 0, 4'd0, 4'd0, 0);
    do_round(1, 0, 4'd3, 4'd0, 0, 0, 4'd0, 4'd0, 0);

    // Timeout, then a normal access
    do_round(1, 0, 4'd7, 4'd0, 0, 0, 4'd0, 4'd0, 1);
    do_round(1, 0, 4'd3, 4'd0, 0, 0, 4'd0, 4'd0, 0);

    // Stale memory ready blocks arbitration
    stale_force = 1'b1;
    @(posedge clk);
    #2;
    start_round(0, 0, 4'd0, 4'd0, 1, 0, 4'd1, 4'd0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      chk("stale ready blocks grant", bus.m_valid, 0);
    end
    stale_force = 1'b0;
    wait_round();

    // Reset in the middle of WAIT, with prio pointing at client 1 beforehand
    do_round(1, 1, 4'd2, 4'd9, 0, 0, 4'd0, 4'd0, 0);
    start_round(0, 0, 4'd0, 4'd0, 1, 0, 4'd4, 4'd0, 1);
    repeat (5) @(posedge clk);
    #2;
    res = 1'b0;
    #1;
    check_cleared("mid-wait reset");
    exp_q.delete();
    bus.valid1   = 1'b0;
    ref_prio     = 1'b0;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    start_round(1, 0, 4'd2, 4'd0, 1, 0, 4'd3, 4'd0, 0);
    @(negedge clk);
    res = 1'b1;
    wait_round();

    // Address/data sweep from client 1
    for (int a = 0; a < D; a++) begin
      mem_lat = int'($urandom_range(0, 3));
      do_round(0, 0, 4'd0, 4'd0, 1, 1, 4'(a), ~4'(a), 0);
    end
    for (int a = D - 1; a >= 0; a--) begin
      mem_lat = int'($urandom_range(0, 3));
      do_round(0, 0, 4'd0, 4'd0, 1, 0, 4'(a), 4'd0, 0);
    end

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      int r;
      r       = int'($urandom_range(0, 2));
      mem_lat = int'($urandom_range(0, 3));
      do_round(r != 1, 1'($urandom), 4'($urandom), 4'($urandom),
               r != 0, 1'($urandom), 4'($urandom), 4'($urandom),
               $urandom_range(0, 9) == 0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the shared single-port memory block.
- Accepts read/write requests from two clients over valid/ready handshakes.
- Serialises the requests onto the memory's valid/wr_rd/addr/wdata port and waits for the memory's ready.
- Returns read data to the winning client, or an error if the memory does not answer within a timeout.

Parameters:
- w, 4, data width; must match the memory.
- d, 16, memory depth.
- n, $clog2(d), address width.
- to, 15, timeout in clk cycles while waiting for memory ready; range 1..255.
- tw, $clog2(to+1), timeout counter width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- res  input  1  asynchronous, active-low reset.
- valid0  input  1  client 0 request.
- wr_rd0  input  1  client 0 direction: 1=write, 0=read.
- addr0  input  n  client 0 address.
- wdata0  input  w  client 0 write data.
- ready0  output  1  client 0 completion pulse.
- rdata0  output  w  client 0 read data.
- err0  output  1  client 0 timeout flag, valid with ready0.
- valid1 / wr_rd1 / addr1 / wdata1 / ready1 / rdata1 / err1: same set for client 1.
- m_valid  output  1  request to memory.
- m_wr_rd  output  1  direction to memory.
- m_addr  output  n  address to memory.
- m_wdata  output  w  write data to memory.
- m_rdata  input  w  read data from memory.
- m_ready  input  1  memory completion, sampled on clk.

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE; prio pointer=0 (client 0 favoured).
  - All outputs 0: m_valid, m_wr_rd, m_addr, m_wdata, ready0/1, rdata0/1, err0/1.
  - Timeout counter=0.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - Arbitration runs only when m_ready==0. A stale memory ready blocks a new issue.
  - Only one client valid: grant that client.
  - Both clients valid: grant the client selected by prio.
  - On grant: latch the client's wr_rd/addr/wdata into m_wr_rd/m_addr/m_wdata, set m_valid=1, record gnt, clear the counter, go to WAIT.
  - No valid, or m_ready still high: stay in IDLE.
- WAIT:
  - m_valid is held at 1 and m_* fields are held stable.
  - m_ready==1 at an edge:
    - If the access is a read, capture m_rdata into rdata[gnt]; for writes rdata[gnt] is unchanged.
    - Set ready[gnt]=1 and err[gnt]=0; m_valid=0; go to RESP.
  - Else if counter==to-1: ready[gnt]=1, err[gnt]=1, m_valid=0, rdata[gnt] unchanged; go to RESP.
  - Else: counter increments.
- RESP (exactly one cycle):
  - ready[gnt] and err[gnt] are high for this one cycle only; cleared on the next edge.
  - prio <= ~gnt, so the granted client gets lowest priority next time.
  - Go to IDLE.
- Client contract:
  - Hold valid and the request fields until the ready pulse.
  - Request fields are latched at grant, so changes after grant are ignored.
  - valid still high in the cycle after the ready pulse is treated as a new request.
- Latency:
  - Grant at edge E0; m_valid visible after E0.
  - Memory answering so m_ready is high at edge E1 gives a client ready pulse in cycle E1..E2.
  - Minimum request-to-ready is 2 cycles; back-to-back throughput is 1 access per 3 cycles minimum.
- Fairness: with both clients continuously valid, grants alternate 0,1,0,1.
- A client that drops valid before grant is never serviced. A drop after grant does not abort the access.
- Reset mid-WAIT or mid-RESP: the access is abandoned immediately, m_valid drops asynchronously, no ready pulse is issued, and prio returns to 0.
- rdata0/rdata1 hold their last captured value until overwritten by a later read.

Test Plan:
- Single write then read: client 0 writes addr=3 wdata=4'hA; client 0 reads addr=3 -> m_valid/m_addr=3 seen, ready0 one-cycle pulses, rdata0=4'hA, err0=0, ready1 never high.
- Simultaneous requests after reset: both valid (c0 write addr=1 data=5, c1 read addr=1) -> c0 granted first. Then c1 granted and rdata1=5. Further continuous requests alternate 0,1,0,1 over 8 accesses.
- Timeout: memory model keeps m_ready=0 -> ready0 and err0 pulse exactly to=15 cycles after grant, m_valid drops, and the next request is arbitrated normally.
- Stale ready: hold m_ready=1 while in IDLE with valid1=1 -> no grant until m_ready returns to 0, then the grant proceeds.
- Reset mid-operation: assert res=0 while in WAIT -> m_valid, ready*, err*, rdata* all 0 immediately. After release, a pending c1 request is serviced with the prio=0 rule.
- Address/data sweep: c1 writes addr 0..15 with data=~addr, then reads all back -> every rdata1 matches, and addr 15 to 0 wraparound is handled without error.
